mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the MIPS pipeline. It owns the architectural HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage over a valid/ready handshake. It sequences a 32-iteration restoring divider and reports busy so the execute stage can stall dependent MFHI/MFLO and further MDU ops. Flush input cancels an in-flight divide on exception or redirect.

## Interface
Parameters: none.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op_valid  in  1  execute stage presents an MDU op
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- src1  in  32  rs value (dividend / multiplicand / MTHI/MTLO data)
- src2  in  32  rt value (divisor / multiplier)
- flush  in  1  cancel in-flight op; drop op presented this cycle
- op_ready  out  1  MDU can accept; high only in IDLE
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when HI/LO are written
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, DIV, FIN. Accept = op_valid & op_ready & ~flush.
- IDLE, accepted MULT/MULTU: 64-bit signed/unsigned product; {hi,lo} <= product at the accepting edge; done=1 in the accepting cycle; stays IDLE.
- IDLE, accepted MTHI/MTLO: hi (resp. lo) <= src1 at the accepting edge; done=1; stays IDLE. Op 6/7: accepted, no state change, done=0.
- IDLE, accepted DIV/DIVU: latch |src1|, |src2| (raw values for DIVU), quotient sign = src1[31]^src2[31], remainder sign = src1[31] (signed only); 6-bit counter <= 0; -> DIV.
- DIV: one restoring step per cycle (shift remainder left with the next dividend bit, subtract divisor, keep the result if it is non-negative, and shift in a quotient bit). Counter increments; after the step with counter==31 -> FIN.
- FIN: apply sign correction (two's-complement negate); done=1; lo <= quotient, hi <= remainder at the edge; -> IDLE.
- Divide by zero is defined by the datapath: DIVU Q=0xFFFFFFFF, R=src1; DIV Q=(src1[31] ? 0x00000001 : 0xFFFFFFFF), R=src1.
- 0x80000000 / 0xFFFFFFFF signed: Q=0x80000000, R=0.
- flush in DIV or FIN: -> IDLE at the next edge, HI/LO unchanged, done forced 0. flush in IDLE: the op is not accepted.
- reset (any state): IDLE, hi=lo=0, counter=0.

## Timing
- Reset values: op_ready=1, busy=0, done=0, hi=0, lo=0.
- MULT/MTHI/MTLO: accepted in cycle 0; new HI/LO visible in cycle 1; op_ready never drops.
- DIV/DIVU: accepted in cycle 0; DIV state in cycles 1-32; FIN in cycle 33 (done=1, busy=1); HI/LO visible and op_ready=1 from cycle 34.
- The execute stage must hold op_valid, op, and operands until op_ready; operands are sampled only at the accepting edge.
- A new op may be accepted in cycle 34, back-to-back with FIN exit, but never during FIN.
- hi/lo are register outputs with no combinational bypass from the in-flight result.

## Configuration
- MDU_DIV_ZERO_FAST_EN defined: an accepted DIV/DIVU with src2==0 goes IDLE -> FIN directly. FIN occurs in cycle 1, and HI/LO are visible in cycle 2. Result values are identical to the iterative ones above.
- MDU_DIV_ZERO_FAST_EN undefined: divide by zero takes the full 33-cycle path.

## Test plan
- MULT 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE in cycle 1. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> done in cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high in cycles 1-33.
- DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then DIVU; flush in cycle 10 -> IDLE in cycle 11; hi=0x12345678 unchanged; done never asserted.
- DIVU 0x55 / 0 -> lo=0xFFFFFFFF, hi=0x55. With the macro, done in cycle 1; without it, done in cycle 33.
- reset asserted in cycle 20 of a DIV -> next cycle op_ready=1, busy=0, hi=lo=0. A flush concurrent with op_valid in IDLE -> op dropped, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS multiply/divide unit controller owning HI/LO.
// Multiplies and MTHI/MTLO complete in the accepting cycle; divides run a
// 32-step restoring divider followed by a sign-correction FIN cycle.
// Optional feature macro: MDU_DIV_ZERO_FAST_EN (divide by zero skips the
// iterative loop and goes straight to FIN with the same result values).
`timescale 1ns/1ps
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic [31:0]        dvs;      // divisor magnitude
  logic [31:0]        dq;       // dividend bits shift out, quotient bits shift in
  logic [31:0]        rem;      // partial remainder
  logic               q_neg, r_neg;
  logic               accept, is_div, is_signed_div, div_zero;
  logic [32:0]        rem_sh, diff;
  logic [31:0]        q_fin, r_fin;
  logic signed [63:0] mul_a, mul_b, prod;

  // Two's-complement magnitude of a value when it is treated as signed.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negate used for final sign correction.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign is_div        = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed_div = (op == OP_DIV);
  assign div_zero      = (src2 == 32'd0);

  // Product: operands extended to 64 bits so the low 64 bits are exact for both forms.
  always_comb begin
    mul_a = (op == OP_MULT) ? {{32{src1[31]}}, src1} : {32'd0, src1};
    mul_b = (op == OP_MULT) ? {{32{src2[31]}}, src2} : {32'd0, src2};
    prod  = mul_a * mul_b;
  end

  // One restoring step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    rem_sh = {rem, dq[31]};
    diff   = rem_sh - {1'b0, dvs};
    q_fin  = cond_neg(dq, q_neg);
    r_fin  = cond_neg(rem, r_neg);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state, handshake and completion pulse.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    accept     = op_valid && (state == S_IDLE) && !flush;
    op_ready   = (state == S_IDLE);
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MULT || op == OP_MULTU || op == OP_MTHI || op == OP_MTLO)
            done = 1'b1;
          if (is_div) begin
`ifdef MDU_DIV_ZERO_FAST_EN
            state_next = div_zero ? S_FIN : S_DIV;
`else
            state_next = S_DIV;
`endif
          end
        end
      end
      S_DIV: begin
        if (flush)             state_next = S_IDLE;
        else if (cnt == 6'd31) state_next = S_FIN;
      end
      S_FIN: begin
        state_next = S_IDLE;
        done       = !flush;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Iteration counter.
  always_ff @(posedge clk) begin
    if (reset)                           cnt <= 6'd0;
    else if (accept && is_div)           cnt <= 6'd0;
    else if (state == S_DIV && !flush)   cnt <= cnt + 6'd1;
  end

  // Divider datapath: operand latch at accept, one restoring step per DIV cycle.
  always_ff @(posedge clk) begin
    if (accept && is_div) begin
      dvs   <= mag(src2, is_signed_div);
      dq    <= mag(src1, is_signed_div);
      rem   <= 32'd0;
      q_neg <= is_signed_div && (src1[31] ^ src2[31]);
      r_neg <= is_signed_div && src1[31];
`ifdef MDU_DIV_ZERO_FAST_EN
      if (div_zero) begin
        dq  <= 32'hFFFF_FFFF;
        rem <= mag(src1, is_signed_div);
      end
`endif
    end else if (state == S_DIV) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        dq  <= {dq[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        dq  <= {dq[30:0], 1'b0};
      end
    end
  end

  // Architectural HI/LO: written by MULT/MTHI/MTLO at accept and by FIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end
        OP_MTHI: hi <= src1;
        OP_MTLO: lo <= src1;
        default: ;
      endcase
    end else if (state == S_FIN && !flush) begin
      hi <= r_fin;
      lo <= q_fin;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
`timescale 1ns/1ps
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        op_ready, busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DZ_CYC = 1;
`else
  localparam int DZ_CYC = 33;
`endif

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .flush(flush),
    .op_ready(op_ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op (MULT/MULTU/MTHI/MTLO): done in cycle 0, HI/LO in cycle 1.
  task automatic run_imm(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    chk({tag, " done c0"}, {31'd0, done}, 32'd1);
    drive_edge();
    op_valid = 1'b0;
    @(negedge clk);
    chk({tag, " rdy c1"}, {31'd0, op_ready}, 32'd1);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    drive_edge();
  endtask

  // Divide: measures the done cycle and busy span, then checks HI/LO.
  task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                         input int ecyc);
    int done_cyc = -1;
    int bcnt = 0;
    logic fin_rdy = 1'b1;
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    drive_edge();
    op_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        done_cyc = c;
        fin_rdy  = op_ready;
        break;
      end
      drive_edge();
    end
    chk({tag, " done cyc"}, done_cyc, ecyc);
    chk({tag, " busy cyc"}, bcnt, ecyc);
    chk({tag, " rdy in FIN"}, {31'd0, fin_rdy}, 32'd0);
    drive_edge();
    @(negedge clk);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " rdy after"}, {31'd0, op_ready}, 32'd1);
    drive_edge();
  endtask

  initial begin
    logic seen;
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 3'd6; src1 = '0; src2 = '0;
    drive_edge();
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("rst op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    drive_edge();

    run_imm("MULT",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_imm("MULTU", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);

    run_div("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("DIVU 100/7", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("DIV min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("DIVU 55/0", 3'd3, 32'h55, 32'd0, 32'hFFFF_FFFF, 32'h55, DZ_CYC);
    run_div("DIV -8/0", 3'd2, 32'hFFFF_FFF8, 32'd0, 32'h0000_0001, 32'hFFFF_FFF8, DZ_CYC);

    // MTHI, then a DIVU flushed in cycle 10.
    run_imm("MTHI", 3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0001);
    seen = 1'b0;
    op_valid = 1'b1; op = 3'd3; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    seen |= done;
    drive_edge();
    op_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      seen |= done;
      drive_edge();
    end
    flush = 1'b1;
    @(negedge clk);
    seen |= done;
    chk("flush c10 busy", {31'd0, busy}, 32'd1);
    drive_edge();
    flush = 1'b0;
    @(negedge clk);
    seen |= done;
    chk("flush c11 busy", {31'd0, busy}, 32'd0);
    chk("flush c11 rdy", {31'd0, op_ready}, 32'd1);
    chk("flush hi", hi, 32'h1234_5678);
    chk("flush lo", lo, 32'h0000_0001);
    for (int c = 0; c < 30; c++) begin
      drive_edge();
      @(negedge clk);
      seen |= done;
    end
    chk("flush no done", {31'd0, seen}, 32'd0);
    chk("flush hi late", hi, 32'h1234_5678);
    drive_edge();

    // Flush concurrent with op_valid in IDLE drops the op.
    op_valid = 1'b1; op = 3'd1; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; flush = 1'b1;
    @(negedge clk);
    chk("idle flush done", {31'd0, done}, 32'd0);
    drive_edge();
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle flush hi", hi, 32'h1234_5678);
    chk("idle flush lo", lo, 32'h0000_0001);
    chk("idle flush busy", {31'd0, busy}, 32'd0);
    drive_edge();

    // No-op code is accepted without effect.
    op_valid = 1'b1; op = 3'd7; src1 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("nop done", {31'd0, done}, 32'd0);
    drive_edge();
    op_valid = 1'b0;
    @(negedge clk);
    chk("nop busy", {31'd0, busy}, 32'd0);
    chk("nop hi", hi, 32'h1234_5678);
    drive_edge();

    // Reset in cycle 20 of a DIV.
    op_valid = 1'b1; op = 3'd2; src1 = 32'd77; src2 = 32'd5;
    drive_edge();
    op_valid = 1'b0;
    for (int c = 1; c < 20; c++) drive_edge();
    @(negedge clk);
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("mid rst rdy", {31'd0, op_ready}, 32'd1);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst hi", hi, 32'd0);
    chk("mid rst lo", lo, 32'd0);
    drive_edge();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
